// File: rtl/score_overlay.sv
// score_overlay: renders both players' scores as seven-segment digits on the VGA stream
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   tick       in   slow game toggle; both edges are events
//   pixel_row  in   current VGA row (10 bits)
//   pixel_col  in   current VGA column (10 bits)
//   score_one  in   player one score (4 bits)
//   score_two  in   player two score (4 bits)
//   score_rgb  out  {r,g,b} overlay colour, registered one clk after the pixel address
//   game_over  out  high while the match is held at its end
//   winner     out  0 = player one, 1 = player two
//
// Build option: define SCORE_FLASH_EN to flash the winner's digit for FLASH_TICKS tick
// edges before holding; without it a win goes straight to the hold state.
module score_overlay #(
    parameter int DIGIT_ONE_X = 280,
    parameter int DIGIT_TWO_X = 340,
    parameter int DIGIT_Y     = 20,
    parameter int SEG_LEN     = 16,
    parameter int SEG_W       = 4,
    parameter int WIN_SCORE   = 9,
    parameter int FLASH_TICKS = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [9:0] pixel_row,
    input  logic [9:0] pixel_col,
    input  logic [3:0] score_one,
    input  logic [3:0] score_two,
    output logic [2:0] score_rgb,
    output logic       game_over,
    output logic       winner
);
    localparam logic [9:0] X1   = 10'(DIGIT_ONE_X);
    localparam logic [9:0] X2   = 10'(DIGIT_TWO_X);
    localparam logic [9:0] Y0   = 10'(DIGIT_Y);
    localparam logic [9:0] W    = 10'(SEG_W);
    localparam logic [9:0] LW   = 10'(SEG_LEN + SEG_W);
    localparam logic [9:0] LW2  = 10'(SEG_LEN + 2 * SEG_W);
    localparam logic [9:0] L2W2 = 10'(2 * SEG_LEN + 2 * SEG_W);
    localparam logic [9:0] L2W3 = 10'(2 * SEG_LEN + 3 * SEG_W);
    localparam logic [3:0] WIN  = 4'(WIN_SCORE);

    typedef enum logic [1:0] {PLAY, WIN_FLASH, HOLD} state_t;

    // Segment mask, bit 0 = a ... bit 6 = g; scores above 9 fall into the default and show 9
    function automatic logic [6:0] seg_mask(input logic [3:0] v);
        case (v)
            4'd0:    seg_mask = 7'h3F;
            4'd1:    seg_mask = 7'h06;
            4'd2:    seg_mask = 7'h5B;
            4'd3:    seg_mask = 7'h4F;
            4'd4:    seg_mask = 7'h66;
            4'd5:    seg_mask = 7'h6D;
            4'd6:    seg_mask = 7'h7D;
            4'd7:    seg_mask = 7'h07;
            4'd8:    seg_mask = 7'h7F;
            default: seg_mask = 7'h6F;
        endcase
    endfunction

    function automatic logic digit_lit(
        input logic [9:0] row,
        input logic [9:0] col,
        input logic [9:0] x0,
        input logic [3:0] v
    );
        logic [9:0] dx, dy;
        logic [6:0] m, s;
        logic       in_box, hx, lx, rx, up, lo;
        dx     = col - x0;
        dy     = row - Y0;
        m      = seg_mask(v);
        // The explicit >= checks reject wrapped differences left of / above the box
        in_box = col >= x0 && row >= Y0 && dx < LW2 && dy < L2W3;
        hx     = dx >= W && dx < LW;
        lx     = dx < W;
        rx     = dx >= LW && dx < LW2;
        up     = dy >= W && dy < LW;
        lo     = dy >= LW2 && dy < L2W2;
        s[0]   = hx && dy < W;
        s[1]   = rx && up;
        s[2]   = rx && lo;
        s[3]   = hx && dy >= L2W2 && dy < L2W3;
        s[4]   = lx && lo;
        s[5]   = lx && up;
        s[6]   = hx && dy >= LW && dy < LW2;
        digit_lit = in_box && |(m & s);
    endfunction

    state_t     r_state, w_next_state;
    logic       r_winner, w_next_winner;
    logic       r_tick_prev, r_live;
    logic [3:0] r_snap_one, r_snap_two;
    logic [2:0] r_rgb;
    logic       w_frame, w_tick_evt, w_win_one, w_win_two, w_blank, w_lit_one, w_lit_two;

    assign w_frame    = pixel_row == 10'd0 && pixel_col == 10'd0;
    assign w_tick_evt = tick ^ r_tick_prev;
    assign w_win_one  = score_one >= WIN;
    assign w_win_two  = score_two >= WIN;

`ifdef SCORE_FLASH_EN
    localparam int CW = ($clog2(FLASH_TICKS) > 4) ? $clog2(FLASH_TICKS) : 4;

    logic [CW-1:0] r_cnt, w_next_cnt;
    logic          w_last;

    assign w_last  = r_cnt == CW'(FLASH_TICKS - 1);
    // Bit 3 toggles every eight tick edges, giving the blink rhythm
    assign w_blank = r_state == WIN_FLASH && r_cnt[3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next_cnt;
        end
    end
`else
    logic w_unused;

    // Without flashing, the tick edge and flash length drive nothing
    assign w_unused = ^{w_tick_evt, FLASH_TICKS[0]};
    assign w_blank  = 1'b0;
`endif

    always_comb begin
        w_next_state  = r_state;
        w_next_winner = r_winner;
`ifdef SCORE_FLASH_EN
        w_next_cnt    = r_cnt;
`endif
        case (r_state)
            PLAY: begin
                // Decided on the incoming snapshot; player one takes a simultaneous win
                if (w_frame && (w_win_one || w_win_two)) begin
                    w_next_winner = !w_win_one;
`ifdef SCORE_FLASH_EN
                    w_next_state  = WIN_FLASH;
`else
                    w_next_state  = HOLD;
`endif
                end
            end
`ifdef SCORE_FLASH_EN
            WIN_FLASH: begin
                if (w_tick_evt) begin
                    w_next_state = w_last ? HOLD : WIN_FLASH;
                    w_next_cnt   = w_last ? '0 : r_cnt + CW'(1);
                end
            end
`endif
            HOLD: begin
                if (w_frame && score_one == 4'd0 && score_two == 4'd0) begin
                    w_next_state = PLAY;
                end
            end
            default: w_next_state = PLAY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= PLAY;
            r_winner <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_winner <= w_next_winner;
        end
    end

    // The loser's digit is never blanked
    assign w_lit_one = r_live && !(w_blank && !r_winner) && digit_lit(pixel_row, pixel_col, X1, r_snap_one);
    assign w_lit_two = r_live && !(w_blank && r_winner) && digit_lit(pixel_row, pixel_col, X2, r_snap_two);

    // r_live keeps the display dark after reset until a real frame snapshot exists
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_prev <= 1'b0;
            r_live      <= 1'b0;
            r_snap_one  <= 4'd0;
            r_snap_two  <= 4'd0;
            r_rgb       <= 3'b000;
        end else begin
            r_tick_prev <= tick;
            if (w_frame) begin
                r_live     <= 1'b1;
                r_snap_one <= score_one;
                r_snap_two <= score_two;
            end
            r_rgb <= {w_lit_one, 1'b0, w_lit_two};
        end
    end

    assign score_rgb = r_rgb;
    assign game_over = r_state == HOLD;
    assign winner    = r_winner;
endmodule

// File: tb/tb_score_overlay.sv
// tb_score_overlay: randomized scoreboard bench for score_overlay
module tb_score_overlay;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [9:0] pixel_row = '0;
    logic [9:0] pixel_col = '0;
    logic [3:0] score_one = '0;
    logic [3:0] score_two = '0;
    logic [2:0] score_rgb;
    logic       game_over;
    logic       winner;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SCORE_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif
    localparam int L = 16, W = 4, X1 = 280, X2 = 340, Y = 20;

    typedef struct {
        logic [2:0] rgb;
        logic       go;
        logic       win;
    } exp_t;

    exp_t  q[$];
    string glyph[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    int m_s1, m_s2, m_edges;
    bit m_live, m_over, m_flash, m_winner, m_tprev;

    score_overlay dut (
        .clk(clk), .reset(reset), .tick(tick),
        .pixel_row(pixel_row), .pixel_col(pixel_col),
        .score_one(score_one), .score_two(score_two),
        .score_rgb(score_rgb), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    function automatic bit inr(int v, int lo, int hi);
        return v >= lo && v < hi;
    endfunction

    function automatic bit seg_hit(byte c, int dx, int dy);
        case (c)
            "a": return inr(dx, W, W + L) && inr(dy, 0, W);
            "b": return inr(dx, W + L, L + 2 * W) && inr(dy, W, L + W);
            "c": return inr(dx, W + L, L + 2 * W) && inr(dy, L + 2 * W, 2 * L + 2 * W);
            "d": return inr(dx, W, W + L) && inr(dy, 2 * L + 2 * W, 2 * L + 3 * W);
            "e": return inr(dx, 0, W) && inr(dy, L + 2 * W, 2 * L + 2 * W);
            "f": return inr(dx, 0, W) && inr(dy, W, L + W);
            "g": return inr(dx, W, W + L) && inr(dy, L + W, L + 2 * W);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit glyph_lit(int dx, int dy, int d);
        string s;
        s = glyph[d > 9 ? 9 : d];
        if (!inr(dx, 0, L + 2 * W) || !inr(dy, 0, 2 * L + 3 * W)) return 1'b0;
        for (int i = 0; i < s.len(); i++)
            if (seg_hit(s[i], dx, dy)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] colour(int row, int col);
        bit blink, p1, p2;
        blink = m_flash && ((m_edges / 8) % 2 == 1);
        p1 = m_live && glyph_lit(col - X1, row - Y, m_s1) && !(blink && !m_winner);
        p2 = m_live && glyph_lit(col - X2, row - Y, m_s2) && !(blink && m_winner);
        return {p1, 1'b0, p2};
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_edges = 0;
        m_live = 0; m_over = 0; m_flash = 0; m_winner = 0; m_tprev = 0;
    endtask

    task automatic model_step(int row, int col);
        bit evt, frame;
        int s1, s2;
        evt = tick != m_tprev;
        m_tprev = tick;
        frame = row == 0 && col == 0;
        s1 = int'(score_one);
        s2 = int'(score_two);
        if (m_flash) begin
            if (evt) begin
                m_edges++;
                if (m_edges == 32) begin
                    m_flash = 0;
                    m_over = 1;
                    m_edges = 0;
                end
            end
        end else if (m_over) begin
            if (frame && s1 == 0 && s2 == 0) m_over = 0;
        end else if (frame && (s1 >= 9 || s2 >= 9)) begin
            m_winner = s1 < 9;
            if (FLASH) begin
                m_flash = 1;
                m_edges = 0;
            end else begin
                m_over = 1;
            end
        end
        if (frame) begin
            m_s1 = s1;
            m_s2 = s2;
            m_live = 1;
        end
    endtask

    task automatic cyc(int row, int col);
        exp_t e;
        pixel_row = 10'(row);
        pixel_col = 10'(col);
        if (!reset) begin
            model_reset();
            e = '{3'b000, 1'b0, 1'b0};
        end else begin
            e.rgb = colour(row, col);
            model_step(row, col);
            e.go  = m_over;
            e.win = m_winner;
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic cyc_rand();
        int r, c;
        if ($urandom_range(0, 2) == 0) tick = ~tick;
        c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 639)) : int'($urandom_range(276, 367));
        r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 479)) : int'($urandom_range(16, 84));
        cyc(r, c);
    endtask

    task automatic run(int n);
        repeat (n) cyc_rand();
    endtask

    task automatic run_to_over();
        for (int i = 0; i < 1000 && !m_over; i++) cyc_rand();
    endtask

    task automatic clear_match();
        run_to_over();
        score_one = 0;
        score_two = 0;
        run(10);
        cyc(0, 0);
        run(20);
    endtask

    task automatic chk(string name, logic [2:0] act, logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("score_rgb", score_rgb, e.rgb);
                chk("game_over", {2'b00, game_over}, {2'b00, e.go});
                chk("winner", {2'b00, winner}, {2'b00, e.win});
            end
        end
    end

    initial begin
        #1 reset = 1'b0;
        @(negedge clk);
        score_one = 5;
        score_two = 3;
        run(4);
        cyc(21, 285);
        reset = 1'b1;
        run(4);
        cyc(0, 0);
        cyc(21, 285);
        cyc(30, 361);
        cyc(30, 301);
        run(150);
        cyc(200, 300);
        reset = 1'b0;
        run(3);
        reset = 1'b1;
        run(3);
        cyc(0, 0);
        run(40);
        repeat (6) begin
            score_one = 4'($urandom_range(0, 8));
            score_two = 4'($urandom_range(0, 8));
            cyc(0, 0);
            run(60);
        end
        score_one = 2;
        cyc(0, 0);
        cyc(50, 281);
        score_one = 3;
        cyc(200, 300);
        cyc(50, 281);
        cyc(21, 285);
        run(60);
        cyc(0, 0);
        cyc(50, 281);
        cyc(21, 285);
        run(60);
        score_one = 12;
        cyc(0, 0);
        cyc(21, 285);
        cyc(50, 100);
        run(60);
        clear_match();
        score_one = 4;
        score_two = 9;
        cyc(0, 0);
        run(40);
        reset = 1'b0;
        run(2);
        reset = 1'b1;
        run(3);
        cyc(0, 0);
        run(50);
        clear_match();
        score_one = 9;
        score_two = 9;
        cyc(0, 0);
        run(30);
        clear_match();
        repeat (3) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
